// File: rtl/rand_draw_arbiter.sv
// Shares one 8-bit pseudo-random generator between two requesters: round-robin
// grant, step/reseed pulses, range check with bounded retries, valid/ack return.
module rand_draw_arbiter #(
  parameter int LO        = 1,
  parameter int HI        = 6,
  parameter int MAX_TRIES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       ack,
  input  logic       reseed,
  input  logic [7:0] gen_num,
  output logic       gen_step,
  output logic       gen_srand,
  output logic [1:0] grant,
  output logic       busy,
  output logic       valid,
  output logic [7:0] value,
  output logic       fallback
);

  typedef enum logic [1:0] {IDLE, STEP, WAIT, DONE} state_t;

  localparam logic [8:0] LO9      = 9'(LO);
  localparam logic [8:0] HI9      = 9'(HI);
  localparam logic [8:0] SPAN     = 9'(HI - LO + 1);
  localparam logic [3:0] LAST_TRY = 4'(MAX_TRIES - 1);

  state_t     state, state_next;
  logic [3:0] tries, tries_next;
  logic       pending, pending_next;
  logic       last, last_next;
  logic [1:0] grant_next;
  logic [7:0] value_next;
  logic       fallback_next, valid_next, busy_next;
  logic       gen_step_next, gen_srand_next;

  logic [8:0] num9;
  logic       in_range;
  logic [7:0] folded;
  logic [1:0] winner;

  // 9-bit arithmetic so that a full 0..255 range (span 256) folds correctly
  assign num9     = {1'b0, gen_num};
  assign in_range = (num9 >= LO9) && (num9 <= HI9);
  assign folded   = 8'(LO9 + (num9 % SPAN));

  // On a tie the requester that did not own the previous draw wins
  always_comb begin
    winner = req;
    if (req == 2'b11) winner = last ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tries     <= '0;
      pending   <= 1'b0;
      last      <= 1'b1;
      grant     <= '0;
      value     <= '0;
      fallback  <= 1'b0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      gen_step  <= 1'b0;
      gen_srand <= 1'b0;
    end else begin
      state     <= state_next;
      tries     <= tries_next;
      pending   <= pending_next;
      last      <= last_next;
      grant     <= grant_next;
      value     <= value_next;
      fallback  <= fallback_next;
      valid     <= valid_next;
      busy      <= busy_next;
      gen_step  <= gen_step_next;
      gen_srand <= gen_srand_next;
    end
  end

  always_comb begin
    state_next     = state;
    tries_next     = tries;
    pending_next   = pending;
    last_next      = last;
    grant_next     = grant;
    value_next     = value;
    fallback_next  = fallback;
    valid_next     = valid;
    busy_next      = busy;
    gen_step_next  = 1'b0;
    gen_srand_next = 1'b0;

    unique case (state)
      IDLE: begin
        if (reseed || pending) begin
          gen_srand_next = 1'b1;
          pending_next   = 1'b0;
        end else if (req != 2'b00) begin
          grant_next    = winner;
          tries_next    = '0;
          busy_next     = 1'b1;
          gen_step_next = 1'b1;
          state_next    = STEP;
        end
      end
      STEP: state_next = WAIT;
      WAIT: begin
        if (in_range) begin
          value_next    = gen_num;
          fallback_next = 1'b0;
          valid_next    = 1'b1;
          state_next    = DONE;
        end else if (tries == LAST_TRY) begin
          value_next    = folded;
          fallback_next = 1'b1;
          valid_next    = 1'b1;
          state_next    = DONE;
        end else begin
          tries_next    = tries + 4'd1;
          gen_step_next = 1'b1;
          state_next    = STEP;
        end
      end
      DONE: begin
        if (ack) begin
          valid_next = 1'b0;
          grant_next = '0;
          busy_next  = 1'b0;
          last_next  = grant[1];
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Reseeds arriving mid-draw collapse into one pending reload
    if (state != IDLE && reseed) pending_next = 1'b1;
  end

endmodule

// File: tb/tb_rand_draw_arbiter.sv
// Bench for rand_draw_arbiter: scripted generator, timeline-based reference
// model compared every cycle, plus directed draws with literal expectations.
module tb_rand_draw_arbiter;

  localparam int LO        = 1;
  localparam int HI        = 6;
  localparam int MAX_TRIES = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic       ack = 1'b0;
  logic       reseed = 1'b0;
  logic [7:0] gen_num = 8'd0;
  logic       gen_step, gen_srand, busy, valid, fallback;
  logic [1:0] grant;
  logic [7:0] value;

  int n_checks = 0;
  int n_pass   = 0;

  int unsigned script [64];
  int gidx = 0;

  // Draw-level model: a draw is a start offset plus a step count and a result
  bit m_active  = 1'b0;
  bit m_fb      = 1'b0;
  bit m_pending = 1'b0;
  bit m_srand   = 1'b0;
  int m_owner   = 0;
  int m_last    = 1;
  int m_d       = 0;
  int m_n       = 1;
  int m_val     = 0;
  int m_idx     = 0;

  always #5 clk = ~clk;

  rand_draw_arbiter #(.LO(LO), .HI(HI), .MAX_TRIES(MAX_TRIES)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .ack      (ack),
    .reseed   (reseed),
    .gen_num  (gen_num),
    .gen_step (gen_step),
    .gen_srand(gen_srand),
    .grant    (grant),
    .busy     (busy),
    .valid    (valid),
    .value    (value),
    .fallback (fallback)
  );

  // Scripted generator: each step presents the next listed value
  always @(posedge clk) begin
    if (gen_step) begin
      gen_num = (gidx < 64) ? 8'(script[gidx]) : 8'd0;
      gidx++;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic a, input logic s);
    req    = r;
    ack    = a;
    reseed = s;
  endtask

  // Outcome of a draw starting at script position m_idx
  task automatic plan_draw();
    bit found = 1'b0;
    m_n = MAX_TRIES;
    for (int k = 0; k < MAX_TRIES; k++) begin
      int v = int'(script[m_idx + k]);
      if (!found && v >= LO && v <= HI) begin
        found = 1'b1;
        m_n   = k + 1;
        m_val = v;
        m_fb  = 1'b0;
      end
    end
    if (!found) begin
      m_val = (LO + int'(script[m_idx + MAX_TRIES - 1]) % (HI - LO + 1)) % 256;
      m_fb  = 1'b1;
    end
    m_idx += m_n;
  endtask

  always @(negedge clk) begin : compare
    bit e_step, e_valid, srand_n;
    int e_grant;
    if (!rst_n) begin
      m_active  = 1'b0;
      m_last    = 1;
      m_pending = 1'b0;
      m_srand   = 1'b0;
    end
    e_valid = m_active && (m_d >= 2 * m_n);
    e_step  = m_active && (m_d < 2 * m_n) && (m_d % 2 == 0);
    e_grant = m_active ? ((m_owner == 1) ? 2 : 1) : 0;
    checkOutput("busy", int'(busy), int'(m_active));
    checkOutput("grant", int'(grant), e_grant);
    checkOutput("gen_step", int'(gen_step), int'(e_step));
    checkOutput("gen_srand", int'(gen_srand), int'(m_srand));
    checkOutput("valid", int'(valid), int'(e_valid));
    if (e_valid) begin
      checkOutput("value", int'(value), m_val);
      checkOutput("fallback", int'(fallback), int'(m_fb));
    end
    if (rst_n) begin
      srand_n = 1'b0;
      if (m_active) begin
        if (reseed) m_pending = 1'b1;
        if (e_valid && ack) begin
          m_active = 1'b0;
          m_last   = m_owner;
        end else begin
          m_d++;
        end
      end else if (reseed || m_pending) begin
        srand_n   = 1'b1;
        m_pending = 1'b0;
      end else if (req != 2'b00) begin
        if (req == 2'b11) m_owner = (m_last == 1) ? 0 : 1;
        else              m_owner = (req == 2'b10) ? 1 : 0;
        m_active = 1'b1;
        m_d      = 0;
        plan_draw();
      end
      m_srand = srand_n;
    end
  end

  // Runs one draw to completion and acks it; keep=0 drops req and pokes a
  // stray ack during STEP, mid_reseed pulses reseed in the first busy cycle
  task automatic doDraw(input logic [1:0] r, input bit keep, input bit mid_reseed,
                        output int cyc, output int steps, output bit first_step,
                        output int g, output int v, output int f);
    applyStimulus(r, 1'b0, 1'b0);
    cyc = 0;
    steps = 0;
    first_step = 1'b0;
    do begin
      tick();
      cyc++;
      if (gen_step) steps++;
      if (cyc == 1) begin
        first_step = gen_step;
        applyStimulus(keep ? r : 2'b00, !keep, mid_reseed);
      end else begin
        applyStimulus(keep ? r : 2'b00, 1'b0, 1'b0);
      end
    end while (!valid && cyc < 40);
    checkOutput("valid_timeout", int'(valid), 1);
    g = int'(grant);
    v = int'(value);
    f = int'(fallback);
    applyStimulus(keep ? r : 2'b00, 1'b1, 1'b0);
    tick();
    applyStimulus(keep ? r : 2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    int cyc, steps, g, v, f;
    bit fs;
    for (int i = 0; i < 64; i++) script[i] = 0;
    script[0] = 4;
    script[1] = 200; script[2] = 0; script[3] = 7; script[4] = 3;
    for (int i = 5; i < 13; i++) script[i] = 200;
    script[13] = 5; script[14] = 6; script[15] = 1;
    script[16] = 2;
    script[17] = 0; script[18] = 255; script[19] = 1;
    script[20] = 4;
    script[21] = 6;

    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_grant", int'(grant), 0);

    $display("[TB] first-try accept");
    doDraw(2'b01, 1'b0, 1'b0, cyc, steps, fs, g, v, f);
    checkOutput("t1_step_at_t1", int'(fs), 1);
    checkOutput("t1_latency", cyc, 3);
    checkOutput("t1_value", v, 4);
    checkOutput("t1_fallback", f, 0);
    checkOutput("t1_grant", g, 1);
    tick();

    $display("[TB] rejection then accept");
    doDraw(2'b10, 1'b0, 1'b0, cyc, steps, fs, g, v, f);
    checkOutput("t2_steps", steps, 4);
    checkOutput("t2_latency", cyc, 9);
    checkOutput("t2_value", v, 3);
    checkOutput("t2_grant", g, 2);
    tick();

    $display("[TB] fallback");
    doDraw(2'b10, 1'b0, 1'b0, cyc, steps, fs, g, v, f);
    checkOutput("t3_steps", steps, 8);
    checkOutput("t3_latency", cyc, 17);
    checkOutput("t3_value", v, 3);
    checkOutput("t3_fallback", f, 1);
    tick();

    $display("[TB] round-robin");
    doDraw(2'b11, 1'b1, 1'b0, cyc, steps, fs, g, v, f);
    checkOutput("t4_grant0", g, 1);
    checkOutput("t4_value0", v, 5);
    doDraw(2'b11, 1'b1, 1'b0, cyc, steps, fs, g, v, f);
    checkOutput("t4_grant1", g, 2);
    checkOutput("t4_value1", v, 6);
    doDraw(2'b11, 1'b1, 1'b0, cyc, steps, fs, g, v, f);
    checkOutput("t4_grant2", g, 1);
    checkOutput("t4_value2", v, 1);
    applyStimulus(2'b00, 1'b0, 1'b0);
    tick();

    $display("[TB] reseed mid-draw");
    doDraw(2'b10, 1'b0, 1'b1, cyc, steps, fs, g, v, f);
    checkOutput("t5b_srand_after_ack", int'(gen_srand), 0);
    tick();
    checkOutput("t5b_srand_serviced", int'(gen_srand), 1);
    tick();

    $display("[TB] reseed in idle with tie");
    applyStimulus(2'b11, 1'b0, 1'b1);
    tick();
    applyStimulus(2'b11, 1'b0, 1'b0);
    checkOutput("t5a_srand", int'(gen_srand), 1);
    checkOutput("t5a_no_grant", int'(grant), 0);
    doDraw(2'b11, 1'b0, 1'b0, cyc, steps, fs, g, v, f);
    checkOutput("t5a_grant", g, 1);
    checkOutput("t5a_latency", cyc, 7);
    checkOutput("t5a_value", v, 1);
    tick();

    $display("[TB] reset mid-wait");
    applyStimulus(2'b01, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_grant", int'(grant), 0);
    checkOutput("t6_rst_busy", int'(busy), 0);
    checkOutput("t6_rst_step", int'(gen_step), 0);
    checkOutput("t6_rst_valid", int'(valid), 0);
    applyStimulus(2'b11, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    doDraw(2'b11, 1'b1, 1'b0, cyc, steps, fs, g, v, f);
    checkOutput("t6_tie_grant", g, 1);
    checkOutput("t6_value", v, 6);
    checkOutput("t6_latency", cyc, 3);
    applyStimulus(2'b00, 1'b0, 1'b0);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
